// File: rtl/alu_rs.sv
// Reservation station feeding the ALU: holds issued ops until both operands are
// known, snoops two CDBs for wakeup, and dispatches one ready entry per cycle.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef CALC_OP_L1_NUM_WIDTH
`define CALC_OP_L1_NUM_WIDTH 4
`endif

module alu_rs #(
  parameter int RS_SIZE       = 8,
  parameter int RS_SIZE_WIDTH = 3
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             need_flush_in,
  input  logic                             issue_valid_in,
  input  logic [`CALC_OP_L1_NUM_WIDTH-1:0] issue_op_L1_in,
  input  logic                             issue_op_L2_in,
  input  logic [31:0]                      issue_vj_in,
  input  logic [31:0]                      issue_vk_in,
  input  logic                             issue_qj_valid_in,
  input  logic                             issue_qk_valid_in,
  input  logic [`ROB_SIZE_WIDTH-1:0]       issue_qj_in,
  input  logic [`ROB_SIZE_WIDTH-1:0]       issue_qk_in,
  input  logic [`ROB_SIZE_WIDTH-1:0]       issue_dest_in,
  input  logic                             cdb0_ready_in,
  input  logic [31:0]                      cdb0_value_in,
  input  logic [`ROB_SIZE_WIDTH-1:0]       cdb0_dependency_in,
  input  logic                             cdb1_ready_in,
  input  logic [31:0]                      cdb1_value_in,
  input  logic [`ROB_SIZE_WIDTH-1:0]       cdb1_dependency_in,
  output logic                             full_out,
  output logic                             alu_valid_out,
  output logic [31:0]                      alu_opr1_out,
  output logic [31:0]                      alu_opr2_out,
  output logic [`ROB_SIZE_WIDTH-1:0]       alu_dependency_out,
  output logic [`CALC_OP_L1_NUM_WIDTH-1:0] alu_op_L1_out,
  output logic                             alu_op_L2_out
);

  localparam int TW = `ROB_SIZE_WIDTH;
  localparam int OW = `CALC_OP_L1_NUM_WIDTH;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_valid;
  logic [RS_SIZE-1:0] qk_valid;
  logic [RS_SIZE-1:0] op_l2;
  logic [OW-1:0]      op_l1 [RS_SIZE];
  logic [31:0]        vj    [RS_SIZE];
  logic [31:0]        vk    [RS_SIZE];
  logic [TW-1:0]      qj    [RS_SIZE];
  logic [TW-1:0]      qk    [RS_SIZE];
  logic [TW-1:0]      dest  [RS_SIZE];

  logic                     free_found;
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic                     sel_found;
  logic [RS_SIZE_WIDTH-1:0] sel_idx;
  logic [31:0]              new_vj;
  logic [31:0]              new_vk;
  logic                     new_qj_valid;
  logic                     new_qk_valid;

  assign full_out = &busy;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = RS_SIZE_WIDTH'(i);
      end
      if (busy[i] && !qj_valid[i] && !qk_valid[i]) begin
        sel_found = 1'b1;
        sel_idx   = RS_SIZE_WIDTH'(i);
      end
    end
  end

  // Operands broadcast in the issue cycle are captured directly.
  always_comb begin
    new_vj       = issue_vj_in;
    new_qj_valid = issue_qj_valid_in;
    new_vk       = issue_vk_in;
    new_qk_valid = issue_qk_valid_in;
    if (issue_qj_valid_in) begin
      if (cdb0_ready_in && cdb0_dependency_in == issue_qj_in) begin
        new_vj       = cdb0_value_in;
        new_qj_valid = 1'b0;
      end else if (cdb1_ready_in && cdb1_dependency_in == issue_qj_in) begin
        new_vj       = cdb1_value_in;
        new_qj_valid = 1'b0;
      end
    end
    if (issue_qk_valid_in) begin
      if (cdb0_ready_in && cdb0_dependency_in == issue_qk_in) begin
        new_vk       = cdb0_value_in;
        new_qk_valid = 1'b0;
      end else if (cdb1_ready_in && cdb1_dependency_in == issue_qk_in) begin
        new_vk       = cdb1_value_in;
        new_qk_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy               <= '0;
      alu_valid_out      <= 1'b0;
      alu_opr1_out       <= '0;
      alu_opr2_out       <= '0;
      alu_dependency_out <= '0;
      alu_op_L1_out      <= '0;
      alu_op_L2_out      <= 1'b0;
    end else if (rdy_in) begin
      if (need_flush_in) begin
        busy          <= '0;
        alu_valid_out <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qj_valid[i]) begin
            if (cdb0_ready_in && cdb0_dependency_in == qj[i]) begin
              vj[i]       <= cdb0_value_in;
              qj_valid[i] <= 1'b0;
            end else if (cdb1_ready_in && cdb1_dependency_in == qj[i]) begin
              vj[i]       <= cdb1_value_in;
              qj_valid[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_valid[i]) begin
            if (cdb0_ready_in && cdb0_dependency_in == qk[i]) begin
              vk[i]       <= cdb0_value_in;
              qk_valid[i] <= 1'b0;
            end else if (cdb1_ready_in && cdb1_dependency_in == qk[i]) begin
              vk[i]       <= cdb1_value_in;
              qk_valid[i] <= 1'b0;
            end
          end
        end

        alu_valid_out <= sel_found;
        if (sel_found) begin
          alu_opr1_out       <= vj[sel_idx];
          alu_opr2_out       <= vk[sel_idx];
          alu_dependency_out <= dest[sel_idx];
          alu_op_L1_out      <= op_l1[sel_idx];
          alu_op_L2_out      <= op_l2[sel_idx];
          busy[sel_idx]      <= 1'b0;
        end

        // Free slot comes from pre-edge busy, so it never aliases the dispatched entry.
        if (issue_valid_in && free_found) begin
          busy[free_idx]     <= 1'b1;
          op_l1[free_idx]    <= issue_op_L1_in;
          op_l2[free_idx]    <= issue_op_L2_in;
          vj[free_idx]       <= new_vj;
          vk[free_idx]       <= new_vk;
          qj_valid[free_idx] <= new_qj_valid;
          qk_valid[free_idx] <= new_qk_valid;
          qj[free_idx]       <= issue_qj_in;
          qk[free_idx]       <= issue_qk_in;
          dest[free_idx]     <= issue_dest_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios with fixed expectations plus
// a randomized run compared against a behavioural reservation-station model.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, need_flush_in, issue_valid_in;
  logic [3:0]  issue_op_L1_in;
  logic        issue_op_L2_in;
  logic [31:0] issue_vj_in, issue_vk_in;
  logic        issue_qj_valid_in, issue_qk_valid_in;
  logic [3:0]  issue_qj_in, issue_qk_in, issue_dest_in;
  logic        cdb0_ready_in, cdb1_ready_in;
  logic [31:0] cdb0_value_in, cdb1_value_in;
  logic [3:0]  cdb0_dependency_in, cdb1_dependency_in;
  logic        full_out, alu_valid_out, alu_op_L2_out;
  logic [31:0] alu_opr1_out, alu_opr2_out;
  logic [3:0]  alu_dependency_out, alu_op_L1_out;

  int check_count = 0;
  int pass_count  = 0;

  alu_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .issue_valid_in(issue_valid_in), .issue_op_L1_in(issue_op_L1_in),
    .issue_op_L2_in(issue_op_L2_in), .issue_vj_in(issue_vj_in), .issue_vk_in(issue_vk_in),
    .issue_qj_valid_in(issue_qj_valid_in), .issue_qk_valid_in(issue_qk_valid_in),
    .issue_qj_in(issue_qj_in), .issue_qk_in(issue_qk_in), .issue_dest_in(issue_dest_in),
    .cdb0_ready_in(cdb0_ready_in), .cdb0_value_in(cdb0_value_in),
    .cdb0_dependency_in(cdb0_dependency_in), .cdb1_ready_in(cdb1_ready_in),
    .cdb1_value_in(cdb1_value_in), .cdb1_dependency_in(cdb1_dependency_in),
    .full_out(full_out), .alu_valid_out(alu_valid_out), .alu_opr1_out(alu_opr1_out),
    .alu_opr2_out(alu_opr2_out), .alu_dependency_out(alu_dependency_out),
    .alu_op_L1_out(alu_op_L1_out), .alu_op_L2_out(alu_op_L2_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a pool of 8 waiting instructions plus the last dispatch.
  typedef struct {
    logic        busy;
    logic [3:0]  op1;
    logic        op2;
    logic [31:0] vj, vk;
    logic        jpend, kpend;
    logic [3:0]  jtag, ktag, dest;
  } slot_t;
  slot_t       pool [8];
  logic        m_valid, m_op2;
  logic [31:0] m_opr1, m_opr2;
  logic [3:0]  m_dep, m_op1;

  function automatic void snoop(inout logic pend, input logic [3:0] tag, inout logic [31:0] val);
    if (!pend) return;
    if (cdb0_ready_in && cdb0_dependency_in == tag) begin val = cdb0_value_in; pend = 1'b0; end
    else if (cdb1_ready_in && cdb1_dependency_in == tag) begin val = cdb1_value_in; pend = 1'b0; end
  endfunction

  function automatic logic model_full();
    for (int i = 0; i < 8; i++) if (!pool[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_edge();
    int sel = -1;
    int fre = -1;
    slot_t s;
    if (rst_in) begin
      foreach (pool[i]) pool[i].busy = 1'b0;
      m_valid = 0; m_opr1 = 0; m_opr2 = 0; m_dep = 0; m_op1 = 0; m_op2 = 0;
      return;
    end
    if (!rdy_in) return;
    if (need_flush_in) begin
      foreach (pool[i]) pool[i].busy = 1'b0;
      m_valid = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (sel < 0 && pool[i].busy && !pool[i].jpend && !pool[i].kpend) sel = i;
      if (fre < 0 && !pool[i].busy) fre = i;
    end
    m_valid = (sel >= 0);
    if (sel >= 0) begin
      m_opr1 = pool[sel].vj; m_opr2 = pool[sel].vk; m_dep = pool[sel].dest;
      m_op1 = pool[sel].op1; m_op2 = pool[sel].op2;
      pool[sel].busy = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (pool[i].busy) begin
        snoop(pool[i].jpend, pool[i].jtag, pool[i].vj);
        snoop(pool[i].kpend, pool[i].ktag, pool[i].vk);
      end
    end
    if (issue_valid_in && fre >= 0) begin
      s.busy = 1'b1; s.op1 = issue_op_L1_in; s.op2 = issue_op_L2_in;
      s.vj = issue_vj_in; s.vk = issue_vk_in;
      s.jpend = issue_qj_valid_in; s.kpend = issue_qk_valid_in;
      s.jtag = issue_qj_in; s.ktag = issue_qk_in; s.dest = issue_dest_in;
      snoop(s.jpend, s.jtag, s.vj);
      snoop(s.kpend, s.ktag, s.vk);
      pool[fre] = s;
    end
  endfunction

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1; need_flush_in = 0; issue_valid_in = 0;
    issue_op_L1_in = 0; issue_op_L2_in = 0; issue_vj_in = 0; issue_vk_in = 0;
    issue_qj_valid_in = 0; issue_qk_valid_in = 0; issue_qj_in = 0; issue_qk_in = 0;
    issue_dest_in = 0; cdb0_ready_in = 0; cdb0_value_in = 0; cdb0_dependency_in = 0;
    cdb1_ready_in = 0; cdb1_value_in = 0; cdb1_dependency_in = 0;
  endtask

  task automatic issue(input logic [31:0] vj, input logic [31:0] vk, input logic qjv,
                       input logic [3:0] qj, input logic [3:0] dest);
    issue_valid_in = 1; issue_vj_in = vj; issue_vk_in = vk; issue_qj_valid_in = qjv;
    issue_qj_in = qj; issue_qk_valid_in = 0; issue_dest_in = dest;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_in = 1; tick(); tick(); rst_in = 0;
  endtask

  task automatic test_reset();
    rdy_in = 0; need_flush_in = 1;
    reset_dut();
    check_count++;
    if (alu_valid_out !== 1'b0 || full_out !== 1'b0) $display("FAIL reset_valid_full: got valid=%0b full=%0b want 0 0", alu_valid_out, full_out);
    else pass_count++;
    check_count++;
    if ({alu_opr1_out, alu_opr2_out, alu_dependency_out, alu_op_L1_out, alu_op_L2_out} !== '0)
      $display("FAIL reset_data: got %h %h %h %h %b want all zero", alu_opr1_out, alu_opr2_out, alu_dependency_out, alu_op_L1_out, alu_op_L2_out);
    else pass_count++;
  endtask

  task automatic test_basic();
    reset_dut();
    issue(5, 7, 0, 0, 3); issue_op_L1_in = 0; issue_op_L2_in = 0;
    tick(); idle_inputs();
    check_count++;
    if (alu_valid_out !== 1'b0) $display("FAIL basic_early: got valid=%0b want 0", alu_valid_out);
    else pass_count++;
    tick();
    check_count++;
    if (alu_valid_out !== 1 || alu_opr1_out !== 5 || alu_opr2_out !== 7 || alu_dependency_out !== 3 || alu_op_L1_out !== 0 || alu_op_L2_out !== 0)
      $display("FAIL basic_dispatch: got v=%0b %0d %0d dep=%0d op=%0d/%0b want 1 5 7 3 0/0", alu_valid_out, alu_opr1_out, alu_opr2_out, alu_dependency_out, alu_op_L1_out, alu_op_L2_out);
    else pass_count++;
    issue(32'hDEAD, 32'hBEEF, 0, 0, 9); issue_op_L1_in = 4'hA; issue_op_L2_in = 1;
    tick(); idle_inputs(); tick();
    check_count++;
    if (alu_valid_out !== 1 || alu_opr1_out !== 32'hDEAD || alu_opr2_out !== 32'hBEEF || alu_dependency_out !== 9 || alu_op_L1_out !== 4'hA || alu_op_L2_out !== 1)
      $display("FAIL basic_op: got v=%0b %h %h dep=%0d op=%h/%0b want 1 dead beef 9 a/1", alu_valid_out, alu_opr1_out, alu_opr2_out, alu_dependency_out, alu_op_L1_out, alu_op_L2_out);
    else pass_count++;
    tick();
    check_count++;
    if (alu_valid_out !== 1'b0) $display("FAIL basic_drain: got valid=%0b want 0", alu_valid_out);
    else pass_count++;
  endtask

  task automatic test_wakeup();
    reset_dut();
    issue(32'h55, 8, 1, 4, 1);
    tick(); idle_inputs(); tick(); tick();
    check_count++;
    if (alu_valid_out !== 1'b0) $display("FAIL wakeup_waits: got valid=%0b want 0", alu_valid_out);
    else pass_count++;
    cdb1_ready_in = 1; cdb1_dependency_in = 4; cdb1_value_in = 32'h1234;
    tick(); idle_inputs();
    check_count++;
    if (alu_valid_out !== 1'b0) $display("FAIL wakeup_same_edge: got valid=%0b want 0", alu_valid_out);
    else pass_count++;
    tick();
    check_count++;
    if (alu_valid_out !== 1 || alu_opr1_out !== 32'h1234 || alu_opr2_out !== 8 || alu_dependency_out !== 1)
      $display("FAIL wakeup_dispatch: got v=%0b %h %0d dep=%0d want 1 1234 8 1", alu_valid_out, alu_opr1_out, alu_opr2_out, alu_dependency_out);
    else pass_count++;
  endtask

  task automatic test_forward();
    reset_dut();
    issue(32'hFFFF, 2, 1, 6, 7);
    cdb0_ready_in = 1; cdb0_dependency_in = 6; cdb0_value_in = 9;
    tick(); idle_inputs(); tick();
    check_count++;
    if (alu_valid_out !== 1 || alu_opr1_out !== 9 || alu_dependency_out !== 7)
      $display("FAIL forward: got v=%0b opr1=%0d dep=%0d want 1 9 7", alu_valid_out, alu_opr1_out, alu_dependency_out);
    else pass_count++;
  endtask

  task automatic test_full();
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      issue(0, i, 1, 4'(i), 4'(i)); tick();
    end
    idle_inputs();
    check_count++;
    if (full_out !== 1'b1) $display("FAIL full_set: got full=%0b want 1", full_out);
    else pass_count++;
    issue(1, 1, 0, 0, 15);
    tick(); idle_inputs(); tick();
    check_count++;
    if (alu_valid_out !== 1'b0) $display("FAIL full_drop: got valid=%0b want 0", alu_valid_out);
    else pass_count++;
    cdb0_ready_in = 1; cdb0_dependency_in = 2; cdb0_value_in = 32'hAA;
    tick(); idle_inputs(); tick();
    check_count++;
    if (alu_valid_out !== 1 || alu_dependency_out !== 2 || alu_opr1_out !== 32'hAA || alu_opr2_out !== 2 || full_out !== 0)
      $display("FAIL full_release: got v=%0b dep=%0d opr1=%h opr2=%0d full=%0b want 1 2 aa 2 0", alu_valid_out, alu_dependency_out, alu_opr1_out, alu_opr2_out, full_out);
    else pass_count++;
  endtask

  task automatic test_flush();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, 1, 4'(10 + i), 4'(i)); tick();
    end
    idle_inputs();
    need_flush_in = 1; tick(); need_flush_in = 0;
    check_count++;
    if (full_out !== 0 || alu_valid_out !== 0) $display("FAIL flush_state: got full=%0b valid=%0b want 0 0", full_out, alu_valid_out);
    else pass_count++;
    cdb0_ready_in = 1; cdb0_dependency_in = 10; cdb1_ready_in = 1; cdb1_dependency_in = 11;
    tick(); cdb1_ready_in = 0; cdb0_dependency_in = 12;
    tick(); idle_inputs(); tick();
    check_count++;
    if (alu_valid_out !== 1'b0) $display("FAIL flush_stale: got valid=%0b want 0", alu_valid_out);
    else pass_count++;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    issue(1, 1, 1, 5, 1); tick();
    issue(2, 2, 1, 5, 2); tick(); idle_inputs();
    cdb0_ready_in = 1; cdb0_dependency_in = 5; cdb0_value_in = 3;
    tick(); idle_inputs();
    rst_in = 1; tick(); rst_in = 0;
    check_count++;
    if (alu_valid_out !== 1'b0 || full_out !== 1'b0) $display("FAIL reset_mid: got valid=%0b full=%0b want 0 0", alu_valid_out, full_out);
    else pass_count++;
    tick(); tick();
    check_count++;
    if (alu_valid_out !== 1'b0) $display("FAIL reset_mid_after: got valid=%0b want 0", alu_valid_out);
    else pass_count++;
  endtask

  task automatic test_rdy_hold();
    reset_dut();
    issue(11, 22, 0, 0, 5); tick(); idle_inputs();
    rdy_in = 0; tick(); tick();
    check_count++;
    if (alu_valid_out !== 1'b0) $display("FAIL rdy_hold_idle: got valid=%0b want 0", alu_valid_out);
    else pass_count++;
    rdy_in = 1; tick(); rdy_in = 0; tick(); tick();
    check_count++;
    if (alu_valid_out !== 1 || alu_opr1_out !== 11 || alu_opr2_out !== 22 || alu_dependency_out !== 5)
      $display("FAIL rdy_hold_out: got v=%0b %0d %0d dep=%0d want 1 11 22 5", alu_valid_out, alu_opr1_out, alu_opr2_out, alu_dependency_out);
    else pass_count++;
    rdy_in = 1; tick();
    check_count++;
    if (alu_valid_out !== 1'b0) $display("FAIL rdy_resume: got valid=%0b want 0", alu_valid_out);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      issue(32'(100 + i), 32'(200 + i), 0, 0, 4'(i)); tick();
      if (i > 0) begin
        check_count++;
        if (alu_valid_out !== 1 || alu_dependency_out !== 4'(i - 1) || alu_opr1_out !== 32'(99 + i))
          $display("FAIL b2b_%0d: got v=%0b dep=%0d opr1=%0d want 1 %0d %0d", i, alu_valid_out, alu_dependency_out, alu_opr1_out, i - 1, 99 + i);
        else pass_count++;
      end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_random();
    logic exp_full;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      need_flush_in = ($urandom_range(0, 39) == 0);
      issue_valid_in = ($urandom_range(0, 9) < 6);
      issue_op_L1_in = 4'($urandom); issue_op_L2_in = 1'($urandom);
      issue_vj_in = $urandom; issue_vk_in = $urandom;
      issue_qj_valid_in = 1'($urandom); issue_qk_valid_in = 1'($urandom);
      issue_qj_in = 4'($urandom); issue_qk_in = 4'($urandom); issue_dest_in = 4'($urandom);
      cdb0_ready_in = 1'($urandom); cdb0_value_in = $urandom; cdb0_dependency_in = 4'($urandom);
      cdb1_ready_in = 1'($urandom); cdb1_value_in = $urandom;
      cdb1_dependency_in = cdb0_dependency_in + 4'($urandom_range(1, 15));
      tick();
      exp_full = model_full();
      check_count++;
      if (alu_valid_out !== m_valid || full_out !== exp_full)
        $display("FAIL rand_ctrl c%0d: got valid=%0b full=%0b want %0b %0b", c, alu_valid_out, full_out, m_valid, exp_full);
      else pass_count++;
      if (m_valid) begin
        check_count++;
        if (alu_opr1_out !== m_opr1 || alu_opr2_out !== m_opr2 || alu_dependency_out !== m_dep || alu_op_L1_out !== m_op1 || alu_op_L2_out !== m_op2)
          $display("FAIL rand_data c%0d: got %h %h %h %h %b want %h %h %h %h %b", c, alu_opr1_out, alu_opr2_out, alu_dependency_out, alu_op_L1_out, alu_op_L2_out, m_opr1, m_opr2, m_dep, m_op1, m_op2);
        else pass_count++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_in = 1;
    idle_inputs();
    test_reset();
    test_basic();
    test_wakeup();
    test_forward();
    test_full();
    test_flush();
    test_reset_mid();
    test_rdy_hold();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
